serial_clk_gen: RTL and testbench
=================================

SERIAL_CLK_GEN -- requirements
Module: serial_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the half-period divisor.
REQ-002 SHALL have parameter CNT_W, default 8, width of the burst-length field.
REQ-003 SHALL have parameter WAIT_W, default 10, width of the guard-length field.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 cfg_half_div  input  DIV_W  half-period length in clk cycles minus 1.
REQ-007 cfg_cpol  input  1  sck idle level.
REQ-008 cfg_cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-009 burst_len  input  CNT_W  number of sck periods minus 1.
REQ-010 wait_len  input  WAIT_W  post-burst guard length in sck periods; 0 = no guard.
REQ-011 start  input  1  burst request; accepted only when ready=1.
REQ-012 abort  input  1  terminate any activity.
REQ-013 ready  output  1  high in IDLE only.
REQ-014 busy  output  1  high in RUN or GUARD.
REQ-015 sck  output  1  generated serial clock, registered.
REQ-016 shift_stb  output  1  one-cycle strobe: launch next bit.
REQ-017 sample_stb  output  1  one-cycle strobe: capture bit.
REQ-018 done  output  1  one-cycle pulse at normal burst+guard completion.
REQ-019 period_idx  output  CNT_W  index of current sck period, 0-based.

Function
REQ-020 States SHALL be IDLE, RUN, GUARD; IDLE->RUN on start&ready, RUN->GUARD (wait_len!=0) or RUN->IDLE (wait_len=0) after final edge, GUARD->IDLE at guard expiry.
REQ-021 cfg_half_div, cfg_cpol, cfg_cpha, burst_len, wait_len SHALL be latched at start acceptance; later changes ignored until next acceptance.
REQ-022 In IDLE sck SHALL equal cfg_cpol (live, registered one cycle).
REQ-023 Half-period counter SHALL clear at acceptance; sck SHALL toggle each time the counter reaches latched half_div, then counter clears; first edge (half_div+1) cycles after acceptance edge.
REQ-024 A burst SHALL produce exactly 2*(burst_len+1) sck edges, ending at cpol level.
REQ-025 Strobes SHALL assert in the same cycle sck shows its new level.
REQ-026 CPHA=0: sample_stb on every leading edge; shift_stb in first RUN cycle and on every trailing edge except the last.
REQ-027 CPHA=1: shift_stb on every leading edge; sample_stb on every trailing edge.
REQ-028 period_idx SHALL increment on each trailing edge except the last, and clear at acceptance.
REQ-029 GUARD SHALL last wait_len*2*(half_div+1) cycles with sck at cpol and no strobes.
REQ-030 done SHALL pulse in the cycle the FSM returns to IDLE from a normal completion; ready=1 the cycle after done.
REQ-031 start while busy SHALL be ignored with no side effect.
REQ-032 abort SHALL have priority over start and completion: next cycle IDLE, sck=cpol, strobes 0, done 0.
REQ-033 half_div=0 SHALL give sck = clk/2 with strobes on consecutive cycles, no dropped edges.
REQ-034 burst_len=2^CNT_W-1 SHALL run 2^CNT_W periods without period_idx overflow error.

Reset
REQ-035 While rst_n=0: state IDLE, ready 1 after release, busy 0, sck = cfg_cpol, strobes 0, done 0, period_idx 0, counters 0.
REQ-036 Reset asserted mid-burst SHALL abort identically to REQ-032 but without done.

Structure
REQ-037 Package serial_clk_pkg SHALL hold the state enum and default parameter constants.
REQ-038 Half-period counter with terminal-count output SHALL be sub-module clk_half_timer, reused for guard counting.

Verification
REQ-039 half_div=2, cpol=0, cpha=0, burst_len=7, wait_len=0 -> 16 edges, period 6 cycles, 8 sample_stb, 8 shift_stb, done 48 cycles after acceptance.
REQ-040 cpol=1, cpha=1, half_div=0, burst_len=0 -> sck 1,0,1; shift at falling, sample at rising; done once.
REQ-041 wait_len=3, half_div=1, burst_len=1 -> guard 12 cycles, sck idle, done after guard, ready next cycle.
REQ-042 abort on 5th edge -> sck=cpol next cycle, no done, next start accepted normally.
REQ-043 start pulsed during RUN and cfg_half_div changed mid-burst -> ignored, timing unchanged.
REQ-044 rst_n low mid-GUARD for 1 cycle -> all outputs reset values, ready high after release.

Source files
------------

// File: rtl/serial_clk_pkg.sv
// Shared types and default widths for the serial clock generator.
package serial_clk_pkg;

    localparam int unsigned DEF_DIV_W  = 8;
    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned DEF_WAIT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

endpackage

// File: rtl/serial_clk_gen_if.sv
// Control/status bundle between a burst requester and serial_clk_gen.
interface serial_clk_gen_if
    import serial_clk_pkg::*;
#(
    parameter int unsigned DIV_W  = DEF_DIV_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned WAIT_W = DEF_WAIT_W
);
    logic [DIV_W-1:0]  cfg_half_div;
    logic              cfg_cpol;
    logic              cfg_cpha;
    logic [CNT_W-1:0]  burst_len;
    logic [WAIT_W-1:0] wait_len;
    logic              start;
    logic              abort;
    logic              ready;
    logic              busy;
    logic              sck;
    logic              shift_stb;
    logic              sample_stb;
    logic              done;
    logic [CNT_W-1:0]  period_idx;

    modport master (
        output cfg_half_div, cfg_cpol, cfg_cpha, burst_len, wait_len, start, abort,
        input  ready, busy, sck, shift_stb, sample_stb, done, period_idx
    );

    modport slave (
        input  cfg_half_div, cfg_cpol, cfg_cpha, burst_len, wait_len, start, abort,
        output ready, busy, sck, shift_stb, sample_stb, done, period_idx
    );

endinterface

// File: rtl/clk_half_timer.sv
// Free-running half-period counter; tc is high on the cycle the count equals limit.
module clk_half_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == limit);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_clk_gen.sv
// Burst serial-clock generator with CPOL/CPHA strobes, optional guard interval and abort.
module serial_clk_gen
    import serial_clk_pkg::*;
#(
    parameter int unsigned DIV_W  = DEF_DIV_W,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned WAIT_W = DEF_WAIT_W
) (
    input logic              clk,
    input logic              rst_n,
    serial_clk_gen_if.slave  bus
);

    state_t            state;
    logic [DIV_W-1:0]  half_div_q;
    logic              cpol_q;
    logic              cpha_q;
    logic [CNT_W-1:0]  burst_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W:0]   guard_cnt;
    logic [WAIT_W:0]   guard_last;
    logic              lead_pend;
    logic              ready_q;
    logic              busy_q;
    logic              sck_q;
    logic              shift_q;
    logic              sample_q;
    logic              done_q;
    logic [CNT_W-1:0]  period_idx_q;
    logic              tmr_clear;
    logic              tmr_en;
    logic              tmr_tc;

    assign tmr_clear  = (state == ST_IDLE) || bus.abort;
    assign tmr_en     = (state != ST_IDLE);
    // Guard counts half periods, so it ends after 2*wait_len timer expiries.
    assign guard_last = {wait_q, 1'b0} - 1'b1;

    clk_half_timer #(
        .W(DIV_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tmr_clear),
        .en    (tmr_en),
        .limit (half_div_q),
        .tc    (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            half_div_q   <= '0;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            burst_q      <= '0;
            wait_q       <= '0;
            guard_cnt    <= '0;
            lead_pend    <= 1'b1;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            sck_q        <= bus.cfg_cpol;
            shift_q      <= 1'b0;
            sample_q     <= 1'b0;
            done_q       <= 1'b0;
            period_idx_q <= '0;
        end else begin
            shift_q  <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            if (bus.abort) begin
                state   <= ST_IDLE;
                ready_q <= (state == ST_IDLE);
                busy_q  <= 1'b0;
                sck_q   <= bus.cfg_cpol;
            end else begin
                case (state)
                    ST_IDLE: begin
                        ready_q <= 1'b1;
                        sck_q   <= bus.cfg_cpol;
                        if (bus.start && ready_q) begin
                            half_div_q   <= bus.cfg_half_div;
                            cpol_q       <= bus.cfg_cpol;
                            cpha_q       <= bus.cfg_cpha;
                            burst_q      <= bus.burst_len;
                            wait_q       <= bus.wait_len;
                            guard_cnt    <= '0;
                            lead_pend    <= 1'b1;
                            period_idx_q <= '0;
                            state        <= ST_RUN;
                            ready_q      <= 1'b0;
                            busy_q       <= 1'b1;
                            shift_q      <= !bus.cfg_cpha;
                        end
                    end
                    ST_RUN: begin
                        if (tmr_tc) begin
                            sck_q     <= ~sck_q;
                            lead_pend <= ~lead_pend;
                            if (lead_pend) begin
                                if (cpha_q) shift_q  <= 1'b1;
                                else        sample_q <= 1'b1;
                            end else begin
                                if (cpha_q) sample_q <= 1'b1;
                                if (period_idx_q == burst_q) begin
                                    state  <= (wait_q != '0) ? ST_GUARD : ST_IDLE;
                                    busy_q <= (wait_q != '0);
                                    done_q <= (wait_q == '0);
                                end else begin
                                    period_idx_q <= period_idx_q + 1'b1;
                                    if (!cpha_q) shift_q <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_GUARD: begin
                        if (tmr_tc) begin
                            if (guard_cnt == guard_last) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                guard_cnt <= guard_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.sck        = sck_q;
    assign bus.shift_stb  = shift_q;
    assign bus.sample_stb = sample_q;
    assign bus.done       = done_q;
    assign bus.period_idx = period_idx_q;

endmodule

// File: tb/tb_serial_clk_gen.sv
// Scoreboard bench for serial_clk_gen: per-cycle expected outputs are queued at start time.
module tb_serial_clk_gen;

    typedef struct packed {
        logic       sck;
        logic       shift;
        logic       sample;
        logic       done;
        logic       busy;
        logic       ready;
        logic [7:0] idx;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic chk_idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    serial_clk_gen_if #(.DIV_W(8), .CNT_W(8), .WAIT_W(10)) bus ();

    serial_clk_gen #(.DIV_W(8), .CNT_W(8), .WAIT_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference timeline: t = cycles after the acceptance edge, sck edge j at t = j*(h+1).
    function automatic exp_t model_at(int unsigned h, bit cpol, bit cpha, int unsigned b,
                                      int unsigned w, int unsigned t);
        int unsigned hp    = h + 1;
        int unsigned ne    = 2 * (b + 1);
        int unsigned t_end = ne * hp + 2 * w * hp;
        int unsigned n     = (t / hp < ne) ? t / hp : ne;
        bit          edg   = (t > 0) && (t % hp == 0) && (t / hp <= ne);
        bit          lead  = edg && ((t / hp) % 2 == 1);
        bit          trail = edg && ((t / hp) % 2 == 0);
        exp_t        e;
        e.chk_idx  = 1'b1;
        e.o.sck    = cpol ^ n[0];
        e.o.shift  = (t == 0) ? !cpha : (cpha ? lead : (trail && (t / hp != ne)));
        e.o.sample = cpha ? trail : lead;
        e.o.done   = (t == t_end);
        e.o.busy   = (t < t_end);
        e.o.ready  = (t > t_end);
        e.o.idx    = 8'((n / 2 < b) ? n / 2 : b);
        return e;
    endfunction

    function automatic exp_t idle_exp(bit cpol, bit rdy, bit chk);
        exp_t e;
        e.o       = '0;
        e.o.sck   = cpol;
        e.o.ready = rdy;
        e.chk_idx = chk;
        return e;
    endfunction

    task automatic push_burst(input int unsigned h, input bit cpol, input bit cpha,
                              input int unsigned b, input int unsigned w,
                              input int unsigned stop_at);
        int unsigned last = 2 * (b + 1) * (h + 1) + 2 * w * (h + 1) + 1;
        if (stop_at != 0) last = stop_at - 1;
        for (int unsigned t = 0; t <= last; t++) sb.push_back(model_at(h, cpol, cpha, b, w, t));
    endtask

    task automatic sample_dut(output obs_t o);
        @(negedge clk);
        o = {bus.sck, bus.shift_stb, bus.sample_stb, bus.done, bus.busy, bus.ready, bus.period_idx};
    endtask

    task automatic issue_start(input int unsigned h, input bit cpol, input bit cpha,
                               input int unsigned b, input int unsigned w);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (bus.ready === 1'b1);
        end
        n_checks++;
        if (!seen) $display("FAIL start_wait: ready=%b required 1 within 200 cycles", bus.ready);
        else n_pass++;
        bus.cfg_half_div = 8'(h);
        bus.cfg_cpol     = cpol;
        bus.cfg_cpha     = cpha;
        bus.burst_len    = 8'(b);
        bus.wait_len     = 10'(w);
        bus.start        = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        rst_n = 1'b0;
        bus.cfg_half_div = '0; bus.cfg_cpol = 1'b1; bus.cfg_cpha = 1'b0;
        bus.burst_len = '0; bus.wait_len = '0; bus.start = 1'b0; bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        sb.push_back(idle_exp(1'b1, 1'b1, 1'b1));
        sb.push_back(idle_exp(1'b1, 1'b1, 1'b1));
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL reset t=%0d: got %b required %b (sck,shf,smp,done,busy,rdy,idx)", t, act, e.o);
            else n_pass++;
            t++;
        end
        rst_n = 1'b1;
        bus.cfg_cpol = 1'b0;
        sb.push_back(idle_exp(1'b0, 1'b1, 1'b1));
        sb.push_back(idle_exp(1'b0, 1'b1, 1'b1));
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL idle_cpol t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            t++;
        end
    endtask

    task automatic test_basic();
        obs_t act;
        exp_t e;
        int unsigned t = 0, n_shift = 0, n_sample = 0, done_t = 0;
        issue_start(2, 1'b0, 1'b0, 7, 0);
        push_burst(2, 1'b0, 1'b0, 7, 0, 0);
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            if (act.shift === 1'b1) n_shift++;
            if (act.sample === 1'b1) n_sample++;
            if (act.done === 1'b1) done_t = t;
            n_checks++;
            if (act !== e.o) $display("FAIL basic t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            t++;
        end
        n_checks++;
        if (n_shift != 8) $display("FAIL basic_shift_count: got %0d required 8", n_shift); else n_pass++;
        n_checks++;
        if (n_sample != 8) $display("FAIL basic_sample_count: got %0d required 8", n_sample); else n_pass++;
        n_checks++;
        if (done_t != 48) $display("FAIL basic_done_time: got %0d required 48", done_t); else n_pass++;
    endtask

    task automatic test_cpol_cpha();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        issue_start(0, 1'b1, 1'b1, 0, 0);
        push_burst(0, 1'b1, 1'b1, 0, 0, 0);
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL cpol1_cpha1 t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            t++;
        end
    endtask

    task automatic test_guard();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        issue_start(1, 1'b0, 1'b0, 1, 3);
        push_burst(1, 1'b0, 1'b0, 1, 3, 0);
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL guard t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            t++;
        end
    endtask

    task automatic test_abort();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        issue_start(1, 1'b1, 1'b0, 3, 2);
        push_burst(1, 1'b1, 1'b0, 3, 2, 10);
        sb.push_back(idle_exp(1'b1, 1'b0, 1'b0));
        repeat (4) sb.push_back(idle_exp(1'b1, 1'b1, 1'b0));
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            if (!e.chk_idx) begin act.idx = '0; e.o.idx = '0; end
            n_checks++;
            if (act !== e.o) $display("FAIL abort t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            if (t == 9) bus.abort = 1'b1;
            if (t == 10) bus.abort = 1'b0;
            t++;
        end
        t = 0;
        issue_start(0, 1'b0, 1'b1, 1, 1);
        push_burst(0, 1'b0, 1'b1, 1, 1, 0);
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL after_abort t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            t++;
        end
    endtask

    task automatic test_ignore_start();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        issue_start(2, 1'b0, 1'b1, 3, 1);
        push_burst(2, 1'b0, 1'b1, 3, 1, 0);
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL ignore_start t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            if (t == 4) begin
                bus.start = 1'b1; bus.cfg_half_div = 8'd5; bus.cfg_cpha = 1'b0; bus.burst_len = '0;
            end
            if (t == 9) bus.start = 1'b0;
            t++;
        end
    endtask

    task automatic test_reset_guard();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        issue_start(1, 1'b1, 1'b1, 1, 3);
        push_burst(1, 1'b1, 1'b1, 1, 3, 12);
        sb.push_back(idle_exp(1'b1, 1'b1, 1'b1));
        sb.push_back(idle_exp(1'b1, 1'b1, 1'b1));
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL reset_guard t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            if (t == 11) rst_n = 1'b0;
            if (t == 12) rst_n = 1'b1;
            t++;
        end
    endtask

    task automatic test_long();
        obs_t act;
        exp_t e;
        int unsigned t = 0;
        issue_start(0, 1'b0, 1'b0, 255, 0);
        push_burst(0, 1'b0, 1'b0, 255, 0, 0);
        while (sb.size() > 0) begin
            sample_dut(act); e = sb.pop_front();
            n_checks++;
            if (act !== e.o) $display("FAIL long t=%0d: got %b required %b", t, act, e.o);
            else n_pass++;
            t++;
        end
    endtask

    task automatic test_back_to_back();
        obs_t act;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            int unsigned h = $urandom_range(0, 3);
            int unsigned b = $urandom_range(0, 5);
            int unsigned w = $urandom_range(0, 2);
            bit cp = 1'($urandom_range(0, 1));
            bit ch = 1'($urandom_range(0, 1));
            int unsigned t = 0;
            issue_start(h, cp, ch, b, w);
            push_burst(h, cp, ch, b, w, 0);
            while (sb.size() > 0) begin
                sample_dut(act); e = sb.pop_front();
                n_checks++;
                if (act !== e.o)
                    $display("FAIL b2b k=%0d h=%0d b=%0d w=%0d cpol=%0d cpha=%0d t=%0d: got %b required %b",
                             k, h, b, w, cp, ch, t, act, e.o);
                else n_pass++;
                t++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cpol_cpha();
        test_guard();
        test_abort();
        test_ignore_start();
        test_reset_guard();
        test_long();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
